// File: rtl/compliance_sig_dumper.sv
// Compliance signature dumper: streams a device-programmed RAM region over the host port, one sig_valid_o pulse per word.
// Device response 1 cycle after every request; host reads stall on host_gnt_i; sig_* has no backpressure.
module compliance_sig_dumper #(
  parameter int unsigned SigMaxWords = 16384
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dev_req_i,
  input  logic        dev_we_i,
  input  logic [31:0] dev_addr_i,
  input  logic [31:0] dev_wdata_i,
  input  logic [3:0]  dev_be_i,
  output logic        dev_rvalid_o,
  output logic [31:0] dev_rdata_o,
  output logic        dev_err_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,
  output logic        sig_valid_o,
  output logic [31:0] sig_addr_o,
  output logic [31:0] sig_data_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int unsigned CntW = $clog2(SigMaxWords + 1);

  localparam logic [7:0] RegBegin  = 8'h00;
  localparam logic [7:0] RegEnd    = 8'h01;
  localparam logic [7:0] RegCtrl   = 8'h02;
  localparam logic [7:0] RegStatus = 8'h03;
  localparam logic [7:0] RegCount  = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } dev_rsp_t;

  state_e          state_q, state_d;
  logic [29:0]     begin_q, end_q;
  logic [31:0]     cur_q;
  logic [CntW-1:0] count_q;
  dev_rsp_t        rsp_d, rsp_q;
  logic            rvalid_q;
  logic            sig_valid_q;
  logic [31:0]     sig_addr_q, sig_data_q;

  logic [31:0] begin_addr, end_addr, span, cur_nxt;
  logic [7:0]  reg_idx;
  logic        busy, full_be, wr_begin, wr_end, start;
  logic        too_many, last_word, word_ok;

  assign begin_addr = {begin_q, 2'b00};
  assign end_addr   = {end_q, 2'b00};
  assign span       = end_addr - begin_addr;
  assign too_many   = (span >> 2) > 32'(SigMaxWords);
  assign cur_nxt    = cur_q + 32'd4;
  // A wrap to 0 ends the dump even though 0 < END.
  assign last_word  = (cur_nxt >= end_addr) || (cur_nxt == 32'd0);
  assign word_ok    = (state_q == ST_WAIT) && host_rvalid_i && !host_err_i;
  assign busy       = (state_q == ST_CHECK) || (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign reg_idx    = dev_addr_i[9:2];
  assign full_be    = (dev_be_i == 4'hF);

  logic unused_ok;
  assign unused_ok = ^{dev_addr_i[31:10], dev_addr_i[1:0], dev_wdata_i[1]};

  // Register decode; writes to BEGIN/END/CTRL while busy are dropped silently.
  always_comb begin
    rsp_d    = '0;
    wr_begin = 1'b0;
    wr_end   = 1'b0;
    start    = 1'b0;
    if (dev_req_i) begin
      case (reg_idx)
        RegBegin: begin
          if (dev_we_i) begin
            if (!full_be) rsp_d.err = 1'b1;
            else          wr_begin  = !busy;
          end else begin
            rsp_d.rdata = begin_addr;
          end
        end
        RegEnd: begin
          if (dev_we_i) begin
            if (!full_be) rsp_d.err = 1'b1;
            else          wr_end    = !busy;
          end else begin
            rsp_d.rdata = end_addr;
          end
        end
        RegCtrl: begin
          if (dev_we_i) begin
            if (!full_be) rsp_d.err = 1'b1;
            else          start     = !busy && dev_wdata_i[0];
          end
        end
        RegStatus: begin
          if (dev_we_i) rsp_d.err   = 1'b1;
          else          rsp_d.rdata = {29'd0, busy, err_o, done_o};
        end
        RegCount: begin
          if (dev_we_i) rsp_d.err   = 1'b1;
          else          rsp_d.rdata = {{(32-CntW){1'b0}}, count_q};
        end
        default: rsp_d.err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (end_addr <= begin_addr) state_d = ST_DONE;
        else if (too_many)          state_d = ST_ERROR;
        else                        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (host_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i)     state_d = ST_ERROR;
          else if (last_word) state_d = ST_DONE;
          else                state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    host_req_o  = 1'b0;
    host_addr_o = '0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      ST_REQ: begin
        host_req_o  = 1'b1;
        host_addr_o = cur_q;
      end
      ST_DONE:  done_o = 1'b1;
      ST_ERROR: err_o  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      begin_q     <= '0;
      end_q       <= '0;
      cur_q       <= '0;
      count_q     <= '0;
      rsp_q       <= '0;
      rvalid_q    <= 1'b0;
      sig_valid_q <= 1'b0;
      sig_addr_q  <= '0;
      sig_data_q  <= '0;
    end else begin
      rvalid_q    <= dev_req_i;
      rsp_q       <= rsp_d;
      sig_valid_q <= 1'b0;
      if (wr_begin) begin_q <= dev_wdata_i[31:2];
      if (wr_end)   end_q   <= dev_wdata_i[31:2];
      if (start) begin
        cur_q   <= begin_addr;
        count_q <= '0;
      end
      if (word_ok) begin
        sig_valid_q <= 1'b1;
        sig_addr_q  <= cur_q;
        sig_data_q  <= host_rdata_i;
        count_q     <= count_q + CntW'(1);
        cur_q       <= cur_nxt;
      end
    end
  end

  assign dev_rvalid_o = rvalid_q;
  assign dev_rdata_o  = rsp_q.rdata;
  assign dev_err_o    = rsp_q.err;
  assign sig_valid_o  = sig_valid_q;
  assign sig_addr_o   = sig_addr_q;
  assign sig_data_o   = sig_data_q;

endmodule

// File: tb/tb_compliance_sig_dumper.sv
// Scoreboard bench: a RAM/host responder, a region model that queues expected words, and a monitor popping on sig_valid_o.
module tb_compliance_sig_dumper;
  localparam int unsigned MaxWords = 16384;
  localparam int          Budget   = 2000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dev_req_i, dev_we_i;
  logic [31:0] dev_addr_i, dev_wdata_i;
  logic [3:0]  dev_be_i;
  logic        dev_rvalid_o, dev_err_o;
  logic [31:0] dev_rdata_o;
  logic        host_req_o, host_gnt_i, host_rvalid_i, host_err_i;
  logic [31:0] host_addr_o, host_rdata_i;
  logic        sig_valid_o, done_o, err_o;
  logic [31:0] sig_addr_o, sig_data_o;

  compliance_sig_dumper dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_addr_i(dev_addr_i),
    .dev_wdata_i(dev_wdata_i), .dev_be_i(dev_be_i),
    .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .sig_valid_o(sig_valid_o), .sig_addr_o(sig_addr_o), .sig_data_o(sig_data_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sig_t;

  sig_t        exp_q[$];
  logic [31:0] ram [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Responder knobs, set by the stimulus thread before each start.
  int          stall_cycles = 0;
  int          resp_lat     = 1;
  int          err_at       = -1;
  int          resp_idx     = 0;
  int          lat_cnt      = 0;
  int          stall_cnt    = 0;
  bit          req_seen     = 0;
  logic [31:0] pend_addr    = '0;
  logic [31:0] stall_addr   = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // RAM behind the host port: grants after stall_cycles, responds resp_lat cycles later.
  initial begin
    host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_rdata_i = '0; host_err_i = 1'b0;
    forever begin
      @(negedge clk_i);
      host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0;
      if (lat_cnt > 0) begin
        check("one_outstanding", host_req_o, 0);
        lat_cnt--;
        if (lat_cnt == 0) begin
          host_rvalid_i = 1'b1;
          host_rdata_i  = mem_rd(pend_addr);
          host_err_i    = (resp_idx == err_at);
          resp_idx++;
        end
      end else if (host_req_o) begin
        req_seen = 1;
        if (stall_cnt == 0) stall_addr = host_addr_o;
        else                check("addr_stable", host_addr_o, stall_addr);
        if (stall_cnt < stall_cycles) begin
          stall_cnt++;
        end else begin
          host_gnt_i = 1'b1;
          pend_addr  = host_addr_o;
          lat_cnt    = resp_lat;
          stall_cnt  = 0;
        end
      end
    end
  end

  initial begin
    sig_t e;
    forever begin
      @(negedge clk_i);
      if (sig_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sig_unexpected: got pulse addr %h data %h, required none", sig_addr_o, sig_data_o);
        end else begin
          e = exp_q.pop_front();
          check("sig_addr", sig_addr_o, e.addr);
          check("sig_data", sig_data_o, e.data);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic dev_access(input logic we, input logic [9:0] off, input logic [31:0] wd,
                            input logic [3:0] be, output logic [31:0] rd, output logic er);
    @(negedge clk_i);
    dev_req_i = 1'b1; dev_we_i = we; dev_addr_i = {22'd0, off}; dev_wdata_i = wd; dev_be_i = be;
    @(negedge clk_i);
    dev_req_i = 1'b0; dev_we_i = 1'b0; dev_be_i = 4'h0;
    check("dev_rvalid", dev_rvalid_o, 1);
    rd = dev_rdata_o;
    er = dev_err_o;
  endtask

  task automatic dev_wr(input logic [9:0] off, input logic [31:0] wd, input logic [3:0] be, output logic er);
    logic [31:0] rd;
    dev_access(1'b1, off, wd, be, rd, er);
  endtask

  task automatic dev_rd(input logic [9:0] off, output logic [31:0] rd, output logic er);
    dev_access(1'b0, off, 32'd0, 4'hF, rd, er);
  endtask

  // Reference: words BEGIN, BEGIN+4, ... below END, truncated at the erroring response.
  task automatic model_dump(input logic [31:0] b, input logic [31:0] e, input int errat,
                            output int nexp, output bit xerr, output bit issues);
    longint lb, le;
    nexp = 0; xerr = 0; issues = 0;
    lb = longint'(b);
    le = longint'(e);
    if (le <= lb) return;
    if (((e - b) >> 2) > MaxWords) begin
      xerr = 1;
      return;
    end
    issues = 1;
    for (longint a = lb; a < le; a += 4) begin
      if (nexp == errat) begin
        xerr = 1;
        break;
      end
      exp_q.push_back(sig_t'{a[31:0], mem_rd(a[31:0])});
      nexp++;
    end
  endtask

  task automatic run_dump(input logic [31:0] b, input logic [31:0] e, input int stall,
                          input int lat, input int errat, input bit poke_busy);
    logic [31:0] rd, bm, em;
    logic        er;
    int          nexp, cyc;
    bit          xerr, issues;
    longint      lim;
    bm = b & 32'hFFFF_FFFC;
    em = e & 32'hFFFF_FFFC;
    dev_wr(10'h000, b, 4'hF, er);
    check("wr_begin_err", er, 0);
    dev_wr(10'h004, e, 4'hF, er);
    check("wr_end_err", er, 0);
    dev_rd(10'h000, rd, er);
    check("begin_readback", rd, bm);
    lim = longint'(bm) + 256;
    for (longint a = longint'(bm); a < longint'(em) && a < lim; a += 4)
      if (!ram.exists(a[31:0])) ram[a[31:0]] = $urandom;
    model_dump(bm, em, errat, nexp, xerr, issues);
    stall_cycles = stall; resp_lat = lat; err_at = errat; resp_idx = 0; req_seen = 0;
    dev_wr(10'h008, 32'd1, 4'hF, er);
    check("start_err", er, 0);
    check("check_no_req", host_req_o, 0);
    check("check_done_clr", done_o | err_o, 0);
    @(negedge clk_i);
    if (issues) begin
      check("req_two_cycles", host_req_o, 1);
    end else begin
      check("no_req", host_req_o, 0);
      check("end_two_cycles", {30'd0, err_o, done_o}, xerr ? 2 : 1);
    end
    if (poke_busy) begin
      dev_wr(10'h000, 32'h0000_5000, 4'hF, er);
      check("busy_wr_err", er, 0);
      dev_wr(10'h008, 32'd1, 4'hF, er);
      check("busy_start_err", er, 0);
      dev_rd(10'h00C, rd, er);
      check("status_busy", rd, 4);
    end
    cyc = 0;
    while (!(done_o || err_o) && cyc < Budget) begin
      @(negedge clk_i);
      cyc++;
    end
    check("dump_in_budget", cyc < Budget, 1);
    @(negedge clk_i);
    check("done", done_o, !xerr);
    check("err", err_o, xerr);
    check("missing_sig", exp_q.size(), 0);
    if (!issues) check("req_never", req_seen, 0);
    dev_rd(10'h010, rd, er);
    check("count", rd, nexp);
    dev_rd(10'h00C, rd, er);
    check("status", rd, xerr ? 2 : 1);
    dev_rd(10'h000, rd, er);
    check("begin_kept", rd, bm);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dev_rvalid"}, dev_rvalid_o, 0);
    check({tag, "_dev_rdata"}, dev_rdata_o, 0);
    check({tag, "_dev_err"}, dev_err_o, 0);
    check({tag, "_host_req"}, host_req_o, 0);
    check({tag, "_host_addr"}, host_addr_o, 0);
    check({tag, "_sig_valid"}, sig_valid_o, 0);
    check({tag, "_sig_addr"}, sig_addr_o, 0);
    check({tag, "_sig_data"}, sig_data_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    logic [31:0] rd, b, e;
    logic        er;
    int          cyc, n, errat;
    rst_ni = 1'b0;
    dev_req_i = 1'b0; dev_we_i = 1'b0; dev_addr_i = '0; dev_wdata_i = '0; dev_be_i = '0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;
    dev_rd(10'h010, rd, er);
    check("reset_count", rd, 0);
    dev_rd(10'h004, rd, er);
    check("reset_end", rd, 0);

    // Register map corner cases.
    dev_wr(10'h014, 32'h1, 4'hF, er);
    check("unmapped_wr_err", er, 1);
    dev_rd(10'h014, rd, er);
    check("unmapped_rd_err", er, 1);
    check("unmapped_rd_data", rd, 0);
    dev_wr(10'h000, 32'h0000_1237, 4'hF, er);
    dev_wr(10'h000, 32'h3333_3333, 4'h3, er);
    check("partial_be_err", er, 1);
    dev_rd(10'h000, rd, er);
    check("partial_be_unchanged", rd, 32'h0000_1234);
    dev_wr(10'h00C, 32'h7, 4'hF, er);
    check("status_wr_err", er, 1);
    dev_wr(10'h010, 32'h7, 4'hF, er);
    check("count_wr_err", er, 1);
    dev_rd(10'h008, rd, er);
    check("ctrl_rd_data", rd, 0);
    check("ctrl_rd_err", er, 0);

    ram[32'h1000] = 32'hAAAA_0001;
    ram[32'h1004] = 32'hBBBB_0002;
    ram[32'h1008] = 32'hCCCC_0003;
    ram[32'h100C] = 32'hDDDD_0004;
    run_dump(32'h1000, 32'h1010, 0, 1, -1, 0);
    run_dump(32'h1000, 32'h1010, 5, 1, -1, 1);
    run_dump(32'h2000, 32'h2000, 0, 1, -1, 0);
    run_dump(32'h1000, 32'h1010, 0, 2, 1, 0);
    run_dump(32'h0000_0000, 32'(4 * (MaxWords + 1)), 0, 1, -1, 0);
    run_dump(32'hFFFF_FFF0, 32'hFFFF_FFFC, 1, 1, -1, 0);

    for (int i = 0; i < 8; i++) begin
      b = 32'h0001_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      n = $urandom_range(0, 10);
      e = (b & 32'hFFFF_FFFC) + 32'(n * 4) + $urandom_range(0, 3);
      if (n == 0 && $urandom_range(0, 1) == 1) e = b - 32'd8;
      errat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
      run_dump(b, e, $urandom_range(0, 3), $urandom_range(1, 3), errat, 0);
    end

    // Reset asserted while a read is outstanding; its late response must be ignored.
    dev_wr(10'h000, 32'h3000, 4'hF, er);
    dev_wr(10'h004, 32'h3040, 4'hF, er);
    stall_cycles = 0; resp_lat = 4; err_at = -1; resp_idx = 0;
    dev_wr(10'h008, 32'd1, 4'hF, er);
    cyc = 0;
    while (!host_req_o && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    check("rst_req_seen", host_req_o, 1);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("rst_wait");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk_i);
    check("post_rst_done", done_o, 0);
    check("post_rst_err", err_o, 0);
    check("post_rst_req", host_req_o, 0);
    dev_rd(10'h010, rd, er);
    check("post_rst_count", rd, 0);
    dev_rd(10'h000, rd, er);
    check("post_rst_begin", rd, 0);
    dev_rd(10'h00C, rd, er);
    check("post_rst_status", rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
